// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, response and ALU-side signals for alu_share_arbiter.
// The slave modport is the arbiter; the master modport is the control unit plus ALU.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             Req0Valid;
  logic             Req0Ready;
  logic [WIDTH-1:0] Req0A;
  logic [WIDTH-1:0] Req0B;
  logic [OPW-1:0]   Req0Op;
  logic             Req1Valid;
  logic             Req1Ready;
  logic [WIDTH-1:0] Req1A;
  logic [WIDTH-1:0] Req1B;
  logic [OPW-1:0]   Req1Op;
  logic             Resp0Valid;
  logic             Resp1Valid;
  logic             RespAck0;
  logic             RespAck1;
  logic [WIDTH-1:0] RespResult;
  logic             RespZero;
  logic [WIDTH-1:0] AluA;
  logic [WIDTH-1:0] AluB;
  logic [OPW-1:0]   AluOp;
  logic [WIDTH-1:0] AluResult;
  logic             AluZero;
  logic             Busy;

  modport slave (
    input  Req0Valid, Req0A, Req0B, Req0Op,
    input  Req1Valid, Req1A, Req1B, Req1Op,
    input  RespAck0, RespAck1,
    input  AluResult, AluZero,
    output Req0Ready, Req1Ready,
    output Resp0Valid, Resp1Valid, RespResult, RespZero,
    output AluA, AluB, AluOp,
    output Busy
  );

  modport master (
    output Req0Valid, Req0A, Req0B, Req0Op,
    output Req1Valid, Req1A, Req1B, Req1Op,
    output RespAck0, RespAck1,
    output AluResult, AluZero,
    input  Req0Ready, Req1Ready,
    input  Resp0Valid, Resp1Valid, RespResult, RespZero,
    input  AluA, AluB, AluOp,
    input  Busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one combinational ALU between the execute datapath
// (port 0) and the PC/address-increment path (port 1), with a registered result.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic               CLK,
  input  logic               RST_n,
  alu_share_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_zero_q, resp_zero_d;
  logic             resp0_valid_q, resp0_valid_d;
  logic             resp1_valid_q, resp1_valid_d;

  logic idle;
  logic grant0;
  logic grant1;
  logic accept0;
  logic accept1;
  logic owner_ack;

  // Ptr names the port that wins a tie; a lone requester always wins.
  always_comb begin
    idle      = (state_q == ST_IDLE);
    grant0    = bus.Req0Valid & (~bus.Req1Valid | ~ptr_q);
    grant1    = bus.Req1Valid & (~bus.Req0Valid |  ptr_q);
    accept0   = idle & grant0;
    accept1   = idle & grant1;
    owner_ack = owner_q ? bus.RespAck1 : bus.RespAck0;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp0_valid_d = resp0_valid_q;
    resp1_valid_d = resp1_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept0 || accept1) begin
          state_d  = ST_EXEC;
          owner_d  = accept1;
          ptr_d    = ~accept1;
          alu_a_d  = accept1 ? bus.Req1A  : bus.Req0A;
          alu_b_d  = accept1 ? bus.Req1B  : bus.Req0B;
          alu_op_d = accept1 ? bus.Req1Op : bus.Req0Op;
        end
      end

      // Operands have been stable on the ALU for a full cycle; capture its outputs.
      ST_EXEC: begin
        state_d       = ST_RESP;
        resp_result_d = bus.AluResult;
        resp_zero_d   = bus.AluZero;
        if (owner_q) begin
          resp1_valid_d = 1'b1;
        end else begin
          resp0_valid_d = 1'b1;
        end
      end

      // Only the owning requester's ack releases the shared ALU.
      ST_RESP: begin
        if (owner_ack) begin
          state_d = ST_IDLE;
          if (owner_q) begin
            resp1_valid_d = 1'b0;
          end else begin
            resp0_valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d       = ST_IDLE;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 1'b0;
      owner_q       <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
    end
  end

  assign bus.Req0Ready  = accept0;
  assign bus.Req1Ready  = accept1;
  assign bus.AluA       = alu_a_q;
  assign bus.AluB       = alu_b_q;
  assign bus.AluOp      = alu_op_q;
  assign bus.RespResult = resp_result_q;
  assign bus.RespZero   = resp_zero_q;
  assign bus.Resp0Valid = resp0_valid_q;
  assign bus.Resp1Valid = resp1_valid_q;
  assign bus.Busy       = ~idle;

  a_single_ready: assert property (@(posedge CLK) disable iff (!RST_n)
    !(bus.Req0Ready && bus.Req1Ready));

  a_single_resp: assert property (@(posedge CLK) disable iff (!RST_n)
    !(bus.Resp0Valid && bus.Resp1Valid));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: stand-in ALU, directed scenarios and
// random two-port traffic checked against a protocol-level reference model.
module tb_alu_share_arbiter;

  logic CLK;
  logic RST_n;

  int n_tests;
  int n_fail;

  int  ack_mode;   // 0 none, 1 both always, 2 random, 3 manual
  logic man_ack0;
  logic man_ack1;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  alu_share_arbiter_if #(.WIDTH(32), .OPW(3)) bus ();

  alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return {31'd0, ($signed(a) < $signed(b))};
      3'd6:    return a << b[4:0];
      default: return ~(a | b);
    endcase
  endfunction

  assign bus.AluResult = alu_f(bus.AluA, bus.AluB, bus.AluOp);
  assign bus.AluZero   = (bus.AluResult == 32'd0);

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Requester ack driver
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (ack_mode)
        0: begin bus.RespAck0 = 1'b0; bus.RespAck1 = 1'b0; end
        1: begin bus.RespAck0 = 1'b1; bus.RespAck1 = 1'b1; end
        2: begin bus.RespAck0 = 1'($urandom_range(0, 1)); bus.RespAck1 = 1'($urandom_range(0, 1)); end
        default: begin bus.RespAck0 = man_ack0; bus.RespAck1 = man_ack1; end
      endcase
    end
  end

  // Reference model and monitor: phase 0 idle, 1 computing, 2 result held.
  int          m_phase;
  logic        m_ptr;
  logic        m_owner;
  logic        m_popped;
  logic [31:0] rec_a, rec_b;
  logic [2:0]  rec_op;
  logic [32:0] exp_rz;

  initial begin
    logic g0, g1, ack_own;
    int   qsz;
    m_phase = 0; m_ptr = 1'b0; m_owner = 1'b0; m_popped = 1'b0;
    rec_a = '0; rec_b = '0; rec_op = '0; exp_rz = '0;
    forever begin
      @(negedge CLK);
      if (!RST_n) begin
        m_phase = 0; m_ptr = 1'b0; m_owner = 1'b0; m_popped = 1'b0;
      end else begin
        g0 = (m_phase == 0) && bus.Req0Valid && (!bus.Req1Valid || m_ptr == 1'b0);
        g1 = (m_phase == 0) && bus.Req1Valid && (!bus.Req0Valid || m_ptr == 1'b1);
        check("req0_ready", bus.Req0Ready, g0);
        check("req1_ready", bus.Req1Ready, g1);
        check("busy", bus.Busy, m_phase != 0);
        check("resp0_valid", bus.Resp0Valid, (m_phase == 2) && !m_owner);
        check("resp1_valid", bus.Resp1Valid, (m_phase == 2) && m_owner);
        if (m_phase != 0) begin
          check("alu_a_held", bus.AluA, rec_a);
          check("alu_b_held", bus.AluB, rec_b);
          check("alu_op_held", bus.AluOp, rec_op);
        end
        if (m_phase == 2) begin
          if (!m_popped) begin
            qsz = m_owner ? exp_q1.size() : exp_q0.size();
            check("scoreboard_has_entry", qsz != 0, 1);
            if (qsz != 0) exp_rz = m_owner ? exp_q1.pop_front() : exp_q0.pop_front();
            m_popped = 1'b1;
          end
          check("resp_result", bus.RespResult, exp_rz[31:0]);
          check("resp_zero", bus.RespZero, exp_rz[32]);
        end
        ack_own = m_owner ? bus.RespAck1 : bus.RespAck0;
        if (m_phase == 0) begin
          if (g0 || g1) begin
            m_owner = g1;
            m_ptr   = !g1;
            rec_a   = g1 ? bus.Req1A  : bus.Req0A;
            rec_b   = g1 ? bus.Req1B  : bus.Req0B;
            rec_op  = g1 ? bus.Req1Op : bus.Req0Op;
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else if (ack_own) begin
          m_phase  = 0;
          m_popped = 1'b0;
        end
      end
    end
  end

  // Issue one request, push its expected result, hold until accepted.
  task automatic drive(input bit port, input int gap, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op);
    int n;
    logic [31:0] r;
    repeat (gap) begin @(posedge CLK); #1; end
    r = alu_f(a, b, op);
    if (port) begin
      bus.Req1A = a; bus.Req1B = b; bus.Req1Op = op; bus.Req1Valid = 1'b1;
      exp_q1.push_back({(r == 32'd0), r});
    end else begin
      bus.Req0A = a; bus.Req0B = b; bus.Req0Op = op; bus.Req0Valid = 1'b1;
      exp_q0.push_back({(r == 32'd0), r});
    end
    n = 0;
    @(negedge CLK);
    while (!(port ? bus.Req1Ready : bus.Req0Ready) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check(port ? "req1_accepted" : "req0_accepted", port ? bus.Req1Ready : bus.Req0Ready, 1);
    @(posedge CLK);
    #1;
    if (port) begin
      bus.Req1Valid = 1'b0; bus.Req1A = $urandom(); bus.Req1B = $urandom(); bus.Req1Op = 3'($urandom());
    end else begin
      bus.Req0Valid = 1'b0; bus.Req0A = $urandom(); bus.Req0B = $urandom(); bus.Req0Op = 3'($urandom());
    end
  endtask

  task automatic rand_drive(input bit port);
    logic [31:0] a, b;
    a = $urandom();
    b = ($urandom_range(0, 3) == 0) ? a : $urandom();
    drive(port, $urandom_range(0, 3), a, b, 3'($urandom()));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (bus.Busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("returned_idle", bus.Busy, 0);
    check("sb_q0_drained", exp_q0.size(), 0);
    check("sb_q1_drained", exp_q1.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.Busy, 0);
    check({tag, "_resp0"}, bus.Resp0Valid, 0);
    check({tag, "_resp1"}, bus.Resp1Valid, 0);
    check({tag, "_result"}, bus.RespResult, 0);
    check({tag, "_zero"}, bus.RespZero, 0);
    check({tag, "_alu_a"}, bus.AluA, 0);
    check({tag, "_alu_b"}, bus.AluB, 0);
    check({tag, "_alu_op"}, bus.AluOp, 0);
    check({tag, "_ready0"}, bus.Req0Ready, 0);
    check({tag, "_ready1"}, bus.Req1Ready, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int n;
    n_tests = 0; n_fail = 0;
    ack_mode = 0; man_ack0 = 1'b0; man_ack1 = 1'b0;
    RST_n = 1'b0;
    bus.Req0Valid = 1'b0; bus.Req0A = '0; bus.Req0B = '0; bus.Req0Op = '0;
    bus.Req1Valid = 1'b0; bus.Req1A = '0; bus.Req1B = '0; bus.Req1Op = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST_n = 1'b1;
    @(posedge CLK);
    #1;

    // Port 0 alone: 5 + 3
    ack_mode = 1;
    drive(1'b0, 0, 32'd5, 32'd3, 3'd0);
    @(negedge CLK);
    check("t2_exec_busy", bus.Busy, 1);
    check("t2_exec_no_resp", bus.Resp0Valid, 0);
    @(negedge CLK);
    check("t2_resp_valid", bus.Resp0Valid, 1);
    check("t2_result", bus.RespResult, 32'd8);
    check("t2_zero", bus.RespZero, 0);
    @(negedge CLK);
    check("t2_back_idle", bus.Busy, 0);
    wait_idle();

    // Port 1 alone: 7 - 7 yields zero
    drive(1'b1, 0, 32'd7, 32'd7, 3'd1);
    @(negedge CLK);
    @(negedge CLK);
    check("t3_resp1_valid", bus.Resp1Valid, 1);
    check("t3_resp0_idle", bus.Resp0Valid, 0);
    check("t3_result", bus.RespResult, 32'd0);
    check("t3_zero", bus.RespZero, 1);
    wait_idle();

    // Reset in the middle of an operation drops it
    ack_mode = 0;
    drive(1'b0, 0, 32'd9, 32'd4, 3'd2);
    #2;
    RST_n = 1'b0;
    #1;
    check_all_zero("t1_async");
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(posedge CLK);
    #3;
    RST_n = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check("t1_no_resp", bus.Resp0Valid | bus.Resp1Valid, 0);
    end
    @(posedge CLK);
    #1;

    // Both ports continuously valid after reset: strict alternation from port 0
    ack_mode = 1;
    fork
      for (int i = 0; i < 4; i++) drive(1'b0, 0, 32'(i * 3 + 1), 32'(i), 3'd0);
      for (int j = 0; j < 4; j++) drive(1'b1, 0, 32'(100 + j), 32'(5 * j), 3'd1);
    join
    wait_idle();

    // Long stall in the result phase, with a wrong-port ack and a queued request
    ack_mode = 3; man_ack0 = 1'b0; man_ack1 = 1'b0;
    fork
      drive(1'b1, 0, 32'd20, 32'd22, 3'd1);
      drive(1'b0, 2, 32'd11, 32'd12, 3'd4);
      begin
        repeat (5) @(posedge CLK);
        #2 man_ack0 = 1'b1;
        repeat (3) @(posedge CLK);
        #2 man_ack0 = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("t5_stalled_resp1", bus.Resp1Valid, 1);
        check("t5_result_held", bus.RespResult, 32'hFFFF_FFFE);
        check("t5_no_ready0", bus.Req0Ready, 0);
        check("t5_req0_waiting", bus.Req0Valid, 1);
        ack_mode = 1;
      end
    join
    wait_idle();

    // Ack of port 1 in the same cycle both ports raise valid; Ptr favours port 0
    ack_mode = 3; man_ack0 = 1'b0; man_ack1 = 1'b0;
    drive(1'b1, 0, 32'd40, 32'd2, 3'd3);
    n = 0;
    @(negedge CLK);
    while (!bus.Resp1Valid && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check("t6_resp1_seen", bus.Resp1Valid, 1);
    man_ack1 = 1'b1;
    @(posedge CLK);
    #1;
    fork
      drive(1'b0, 0, 32'd6, 32'd7, 3'd0);
      drive(1'b1, 0, 32'd8, 32'd9, 3'd2);
      begin
        @(negedge CLK);
        check("t6_no_early_accept", bus.Req0Ready, 0);
        @(posedge CLK);
        ack_mode = 1;
        @(negedge CLK);
        check("t6_accept0_after_idle", bus.Req0Ready, 1);
        check("t6_port1_waits", bus.Req1Ready, 0);
      end
    join
    man_ack1 = 1'b0;
    wait_idle();

    // Random traffic with random acks (including wrong-port and idle acks)
    ack_mode = 2;
    fork
      for (int i = 0; i < 30; i++) rand_drive(1'b0);
      for (int j = 0; j < 30; j++) rand_drive(1'b1);
    join
    ack_mode = 1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
